rgb_blink_scheduler: RTL



---
 rtl/rgb_blink_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/rgb_blink_scheduler.sv
// rgb_blink_scheduler: merges host register writes with RGB blink toggles onto one write port.
// rev 1.0
`default_nettype none

module rgb_blink_scheduler #(
  parameter int PRESCALE = 12000,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_wr_valid,
  input  logic [7:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  output logic       host_wr_ready,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [2:0] phase,
  output logic [2:0] overrun
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]             ps_cnt;
  logic [2:0][CNT_W-1:0]       on_ticks, off_ticks, cnt;
  logic [2:0][CNT_W-1:0]       cnt_nxt, cnt_inc, dur;
  logic [2:0]                  en, pending, phase_nxt, set_pend, grant_vec, ovr_clr;
  logic                        last_grant_host;
  logic                        tick, host_fwd, cfg_wr, en_wr, sched_req, grant_host, grant_sched;
  logic [1:0]                  sel;

  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
  assign host_fwd = host_wr_valid && (host_wr_addr[7:3] == 5'b00000);
  assign cfg_wr   = host_wr_valid && (host_wr_addr[7:3] == 5'b00010);
  assign en_wr    = cfg_wr && (host_wr_addr[2:0] == 3'd6);
  assign ovr_clr  = (cfg_wr && (host_wr_addr[2:0] == 3'd7)) ? host_wr_data[2:0] : 3'b000;

  assign sched_req = |pending;
  assign sel       = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);

  // On contention the side that did not win last time gets the port.
  assign grant_host    = host_fwd && (!sched_req || !last_grant_host);
  assign grant_sched   = sched_req && (!host_fwd || last_grant_host);
  assign host_wr_ready = !host_fwd || grant_host;
  assign grant_vec     = grant_sched ? (3'b001 << sel) : 3'b000;

  always_comb begin
    phase_nxt = phase;
    set_pend  = 3'b000;
    cnt_nxt   = cnt;
    cnt_inc   = cnt;
    dur       = off_ticks;
    for (int c = 0; c < 3; c++) begin
      dur[c]     = phase[c] ? on_ticks[c] : off_ticks[c];
      cnt_inc[c] = cnt[c] + CNT_W'(1);
      // An enable edge overrides any tick landing in the same cycle.
      if (en_wr && (host_wr_data[c] != en[c])) begin
        phase_nxt[c] = host_wr_data[c];
        set_pend[c]  = 1'b1;
        if (host_wr_data[c]) cnt_nxt[c] = '0;
      end else if (en[c] && tick && (dur[c] != '0)) begin
        if (cnt_inc[c] == dur[c]) begin
          cnt_nxt[c]   = '0;
          phase_nxt[c] = ~phase[c];
          set_pend[c]  = 1'b1;
        end else begin
          cnt_nxt[c] = cnt_inc[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt          <= '0;
      on_ticks        <= '0;
      off_ticks       <= '0;
      cnt             <= '0;
      en              <= 3'b000;
      pending         <= 3'b000;
      phase           <= 3'b000;
      overrun         <= 3'b000;
      last_grant_host <= 1'b0;
      reg_wr_en       <= 1'b0;
      reg_wr_addr     <= 8'h00;
      reg_wr_data     <= 8'h00;
    end else begin
      ps_cnt  <= tick ? '0 : ps_cnt + PS_W'(1);
      cnt     <= cnt_nxt;
      phase   <= phase_nxt;
      pending <= (pending & ~grant_vec) | set_pend;
      overrun <= (overrun & ~ovr_clr) | (set_pend & pending & ~grant_vec);
      if (en_wr) en <= host_wr_data[2:0];
      for (int c = 0; c < 3; c++) begin
        if (cfg_wr && (host_wr_addr[2:0] == 3'(2 * c)))     on_ticks[c]  <= CNT_W'(host_wr_data);
        if (cfg_wr && (host_wr_addr[2:0] == 3'(2 * c + 1))) off_ticks[c] <= CNT_W'(host_wr_data);
      end
      reg_wr_en <= grant_host || grant_sched;
      if (grant_host) begin
        reg_wr_addr     <= host_wr_addr;
        reg_wr_data     <= host_wr_data;
        last_grant_host <= 1'b1;
      end else if (grant_sched) begin
        // LEDs are active-low: phase on drives 0.
        reg_wr_addr     <= {5'b00000, sel, 1'b1};
        reg_wr_data     <= {7'd0, ~phase[sel]};
        last_grant_host <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
